// File: rtl/wbarb_rr_pkg.sv
// wbarb_rr_pkg: shared types and the round-robin pick function for the
// Wishbone B4 pipelined round-robin arbiter.
//   state_t  : arbiter FSM state (IDLE, BUSY)
//   pick_t   : result of a round-robin search (valid + winning index)
//   rr_pick  : first set bit of req at or after ptr, wrapping at n
package wbarb_rr_pkg;

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   // Widest request vector the pick function handles; masters beyond this
   // are not supported.
   localparam int RR_MAX   = 16;
   localparam int RR_IDX_W = $clog2(RR_MAX);

   typedef struct packed {
      logic        valid;
      int unsigned idx;
   } pick_t;

   // Search n request bits starting at ptr (ptr < n), wrapping back to 0.
   function automatic pick_t rr_pick(input logic [RR_MAX-1:0] req,
                                     input int unsigned       ptr,
                                     input int unsigned       n);
      pick_t       p;
      int unsigned j;
      p = '0;
      j = 0;
      for (int unsigned k = 0; k < RR_MAX; k++) begin
         if (k < n) begin
            j = ptr + k;
            if (j >= n) j = j - n;
            if (!p.valid && req[j[RR_IDX_W-1:0]]) begin
               p.valid = 1'b1;
               p.idx   = j;
            end
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/wbarb_rr_if.sv
// wbarb_rr_if: Wishbone B4 pipelined bus bundle, N lanes wide on the
// request side.  The master-facing side of the arbiter uses N=NUM_MASTERS
// (one lane per master, read data broadcast); the slave-facing side uses N=1.
//   cyc/stb/we  : per-lane cycle, strobe, write enable   (master -> slave)
//   adr/dat_w   : per-lane address and write data        (master -> slave)
//   sel         : per-lane byte selects                  (master -> slave)
//   dat_r       : read data, shared by all lanes         (slave -> master)
//   ack/stall   : per-lane acknowledge and stall         (slave -> master)
interface wbarb_rr_if #(
   parameter int N  = 1,
   parameter int AW = 32,
   parameter int DW = 32,
   parameter int NB = 4
);
   logic [N-1:0]         cyc;
   logic [N-1:0]         stb;
   logic [N-1:0]         we;
   logic [N-1:0][AW-1:0] adr;
   logic [N-1:0][DW-1:0] dat_w;
   logic [N-1:0][NB-1:0] sel;
   logic [DW-1:0]        dat_r;
   logic [N-1:0]         ack;
   logic [N-1:0]         stall;

   modport master (output cyc, stb, we, adr, dat_w, sel,
                   input  dat_r, ack, stall);
   modport slave  (input  cyc, stb, we, adr, dat_w, sel,
                   output dat_r, ack, stall);
endinterface

// File: rtl/wbarb_rr_pick_idx.sv
// rr_pick_idx: combinational round-robin priority encoder.
//   i_req   : request vector, one bit per master
//   i_ptr   : index with highest priority this round (must be < N)
//   o_idx   : first requester at or after i_ptr, wrapping
//   o_valid : at least one request present
module rr_pick_idx
   import wbarb_rr_pkg::*;
#(
   parameter int N     = 2,
   parameter int IDX_W = 1
) (
   input  logic [N-1:0]     i_req,
   input  logic [IDX_W-1:0] i_ptr,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_valid
);

   pick_t w_pick;

   always_comb begin
      w_pick = rr_pick(RR_MAX'(i_req), 32'(i_ptr), N);
   end

   assign o_valid = w_pick.valid;
   assign o_idx   = IDX_W'(w_pick.idx);

endmodule

// File: rtl/wbarb_rr.sv
// wbarb_rr: round-robin Wishbone B4 pipelined arbiter sharing one slave
// among NUM_MASTERS masters.  A grant covers the owner's whole CYC; the
// arbiter counts accepted-but-unacked requests, throttles the owner at
// MAX_OUTSTANDING, and rotates priority to owner+1 when the owner drops CYC.
//   clk    : clock
//   rst    : asynchronous reset, active high
//   m_bus  : master side, one lane per master (read data broadcast)
//   s_bus  : slave side, single lane
module wbarb_rr
   import wbarb_rr_pkg::*;
#(
   parameter int NUM_MASTERS     = 2,
   parameter int DATA_WIDTH      = 32,
   parameter int ADDR_WIDTH      = 32,
   parameter int BYTE_WIDTH      = 8,
   parameter int NUM_BYTES       = DATA_WIDTH / BYTE_WIDTH,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic         clk,
   input  logic         rst,
   wbarb_rr_if.slave    m_bus,
   wbarb_rr_if.master   s_bus
);

   localparam int IDX_W = $clog2(NUM_MASTERS);
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

   state_t                  r_state, w_state_nxt;
   logic [IDX_W-1:0]        r_owner;
   logic [IDX_W-1:0]        r_rr_ptr;
   logic [CNT_W-1:0]        r_outst;

   logic [IDX_W-1:0]        w_pick_idx;
   logic                    w_pick_vld;
   logic                    w_full;
   logic                    w_release;
   logic                    w_accept;
   logic [ADDR_WIDTH-1:0]   w_own_adr;
   logic [DATA_WIDTH-1:0]   w_own_dat;
   logic [NUM_BYTES-1:0]    w_own_sel;

   rr_pick_idx #(
      .N     (NUM_MASTERS),
      .IDX_W (IDX_W)
   ) u_pick (
      .i_req   (m_bus.cyc),
      .i_ptr   (r_rr_ptr),
      .o_idx   (w_pick_idx),
      .o_valid (w_pick_vld)
   );

   assign w_full    = (r_outst == CNT_W'(MAX_OUTSTANDING));
   // Owner dropping CYC abandons the cycle: unacked requests are forgotten.
   assign w_release = (r_state == BUSY) && !m_bus.cyc[r_owner];
   assign w_accept  = s_bus.cyc[0] & s_bus.stb[0] & ~s_bus.stall[0];

   // ---------------- state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // ---------------- next state ----------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_pick_vld) w_state_nxt = BUSY;
         BUSY:    if (w_release)  w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // ---------------- owner / priority / outstanding ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_owner  <= '0;
         r_rr_ptr <= '0;
         r_outst  <= '0;
      end else begin
         if (r_state == IDLE && w_pick_vld) r_owner <= w_pick_idx;
         if (w_release) begin
            r_rr_ptr <= (r_owner == IDX_W'(NUM_MASTERS - 1)) ? '0 : r_owner + 1'b1;
            r_outst  <= '0;
         end else if (r_state == BUSY) begin
            // Accept and ack in the same cycle cancel; an ack with nothing
            // outstanding is spurious and must not underflow.  Accept is
            // blocked while full, so the count never exceeds the limit.
            if (w_accept && !s_bus.ack[0])
               r_outst <= r_outst + 1'b1;
            else if (!w_accept && s_bus.ack[0] && r_outst != '0)
               r_outst <= r_outst - 1'b1;
         end
      end
   end

   // ---------------- outputs ----------------
   assign w_own_adr = m_bus.adr[r_owner];
   assign w_own_dat = m_bus.dat_w[r_owner];
   assign w_own_sel = m_bus.sel[r_owner];

   always_comb begin
      s_bus.cyc      = '0;
      s_bus.stb      = '0;
      s_bus.we       = '0;
      s_bus.adr[0]   = w_own_adr;
      s_bus.dat_w[0] = w_own_dat;
      s_bus.sel[0]   = w_own_sel;
      m_bus.ack      = '0;
      m_bus.stall    = '1;
      m_bus.dat_r    = s_bus.dat_r;
      if (r_state == BUSY) begin
         s_bus.cyc[0]         = m_bus.cyc[r_owner];
         s_bus.stb[0]         = m_bus.stb[r_owner] & ~w_full;
         s_bus.we[0]          = m_bus.we[r_owner];
         m_bus.stall[r_owner] = s_bus.stall[0] | w_full;
         m_bus.ack[r_owner]   = s_bus.ack[0];
      end
   end

endmodule

// File: tb/tb_wbarb_rr.sv
// tb_wbarb_rr: self-checking bench for wbarb_rr (2 masters, 4 outstanding).
// A fixed table covers arbitration order and slave stall; hand sequences
// cover read/write, throttling, abandoned cycles and mid-burst reset; a
// random phase drives both masters and a randomly stalling/acking RAM,
// checked every cycle against a grant/counter reference model.
module tb_wbarb_rr;

   localparam int NM = 2, AW = 32, DW = 32, NB = 4, MAXO = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   wbarb_rr_if #(.N(NM), .AW(AW), .DW(DW), .NB(NB)) m_if ();
   wbarb_rr_if #(.N(1),  .AW(AW), .DW(DW), .NB(NB)) s_if ();

   wbarb_rr #(
      .NUM_MASTERS(NM), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
      .BYTE_WIDTH(8), .MAX_OUTSTANDING(MAXO)
   ) dut (
      .clk(clk), .rst(rst), .m_bus(m_if), .s_bus(s_if)
   );

   int vec_n = 0, err_n = 0;

   // reference model: grant state and outstanding count
   bit mb_busy;
   int mb_own, mb_ptr, mb_out;
   // RAM slave model
   logic [31:0] mem [0:255];
   logic [31:0] pend [$];
   bit ack_hold, stall_force, rnd;
   // observed bookkeeping
   int ackcnt [NM];
   int acccnt [NM];
   logic [31:0] rd_last;

   typedef struct packed {
      logic [1:0] cyc, stb;
      logic       sack, sstall;
      logic       ecyc, estb;
      logic [1:0] eack, estall;
   } vec_t;
   vec_t tbl [17];

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      vec_n++;
      if (got !== exp) begin
         err_n++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic drive(input int i, input bit c, input bit s, input bit w,
                        input logic [31:0] a, input logic [31:0] d);
      m_if.cyc[i]   = c;
      m_if.stb[i]   = s;
      m_if.we[i]    = w;
      m_if.adr[i]   = a;
      m_if.dat_w[i] = d;
      m_if.sel[i]   = 4'hF;
   endtask

   // One clock: slave responds, outputs checked against the model,
   // models advance, then wait for the next falling edge.
   task automatic cycle();
      logic [NM-1:0] e_ack, e_stall;
      logic e_cyc, e_stb, e_we, acc;
      logic [7:0] a;
      bit found;
      s_if.stall[0] = stall_force | (rnd && ($urandom_range(0, 3) == 0));
      s_if.ack[0]   = 1'b0;
      s_if.dat_r    = $urandom;
      if (pend.size() > 0 && !ack_hold && (!rnd || $urandom_range(0, 2) != 0)) begin
         s_if.ack[0] = 1'b1;
         s_if.dat_r  = pend[0];
      end else if (rnd && pend.size() == 0 && $urandom_range(0, 15) == 0) begin
         s_if.ack[0] = 1'b1;  // spurious ack
      end
      #1;
      e_cyc   = mb_busy && m_if.cyc[mb_own];
      e_stb   = mb_busy && m_if.stb[mb_own] && (mb_out < MAXO);
      e_we    = mb_busy && m_if.we[mb_own];
      e_ack   = '0;
      e_stall = '1;
      if (mb_busy) begin
         e_ack[mb_own]   = s_if.ack[0];
         e_stall[mb_own] = s_if.stall[0] || (mb_out == MAXO);
      end
      check("ctl", 128'({s_if.cyc[0], s_if.stb[0], s_if.we[0], m_if.ack, m_if.stall, m_if.dat_r}),
                   128'({e_cyc, e_stb, e_we, e_ack, e_stall, s_if.dat_r}));
      if (e_stb)
         check("bus", 128'({s_if.adr[0], s_if.dat_w[0], s_if.sel[0]}),
                      128'({m_if.adr[mb_own], m_if.dat_w[mb_own], m_if.sel[mb_own]}));
      for (int i = 0; i < NM; i++) begin
         if (m_if.ack[i]) begin ackcnt[i]++; rd_last = m_if.dat_r; end
         if (m_if.cyc[i] && m_if.stb[i] && !m_if.stall[i]) acccnt[i]++;
      end
      // RAM: respond in order to whatever the arbiter actually put on the bus
      if (s_if.ack[0] && pend.size() > 0) void'(pend.pop_front());
      if (!rst && s_if.cyc[0] && s_if.stb[0] && !s_if.stall[0]) begin
         a = s_if.adr[0][9:2];
         if (s_if.we[0]) begin
            for (int b = 0; b < NB; b++)
               if (s_if.sel[0][b]) mem[a][8*b +: 8] = s_if.dat_w[0][8*b +: 8];
            pend.push_back($urandom);
         end else begin
            pend.push_back(mem[a]);
         end
      end
      // reference model
      acc = e_cyc && e_stb && !s_if.stall[0];
      if (rst) begin
         mb_busy = 0; mb_own = 0; mb_ptr = 0; mb_out = 0;
      end else if (!mb_busy) begin
         found = 0;
         for (int k = 0; k < NM; k++) begin
            if (!found && m_if.cyc[(mb_ptr + k) % NM]) begin
               found = 1; mb_busy = 1; mb_own = (mb_ptr + k) % NM;
            end
         end
      end else if (!m_if.cyc[mb_own]) begin
         mb_busy = 0; mb_ptr = (mb_own + 1) % NM; mb_out = 0;
      end else if (acc && !s_if.ack[0]) begin
         mb_out++;
      end else if (!acc && s_if.ack[0] && mb_out > 0) begin
         mb_out--;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      mb_busy = 0; mb_own = 0; mb_ptr = 0; mb_out = 0;
      pend.delete();
      ack_hold = 0; stall_force = 0; rnd = 0;
      for (int i = 0; i < NM; i++) begin drive(i, 0, 0, 0, 0, 0); ackcnt[i] = 0; acccnt[i] = 0; end
      s_if.ack[0] = 1'b0; s_if.stall[0] = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic issue(input int i, input bit w, input logic [31:0] a, input logic [31:0] d);
      int a0, n;
      a0 = acccnt[i]; n = 0;
      drive(i, 1, 1, w, a, d);
      while (acccnt[i] == a0 && n < 20) begin cycle(); n++; end
      check("issue_accept", 128'(acccnt[i] - a0), 128'(1));
      m_if.stb[i] = 1'b0;
   endtask

   task automatic wait_acks(input int i, input int tgt, input string name);
      int n;
      n = 0;
      while (ackcnt[i] < tgt && n < 40) begin cycle(); n++; end
      check(name, 128'(ackcnt[i]), 128'(tgt));
   endtask

   initial begin
      int a0, b0, n, tot;
      for (int i = 0; i < 256; i++) mem[i] = '0;
      for (int i = 0; i < NM; i++) drive(i, 0, 0, 0, 0, 0);
      s_if.ack[0] = 1'b0; s_if.stall[0] = 1'b0; s_if.dat_r = '0;

      //           cyc    stb    ack   stl   ecyc  estb  eack   estall
      tbl[0]  = '{2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b11};
      tbl[1]  = '{2'b11, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b10};
      tbl[2]  = '{2'b11, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 2'b10};
      tbl[3]  = '{2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10};
      tbl[4]  = '{2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b11};
      tbl[5]  = '{2'b10, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b01};
      tbl[6]  = '{2'b11, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 2'b01};
      tbl[7]  = '{2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01};
      tbl[8]  = '{2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b11};
      tbl[9]  = '{2'b11, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 2'b11};
      tbl[10] = '{2'b11, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 2'b11};
      tbl[11] = '{2'b11, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 2'b11};
      tbl[12] = '{2'b11, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b10};
      tbl[13] = '{2'b11, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 2'b10};
      tbl[14] = '{2'b11, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 2'b10};
      tbl[15] = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10};
      tbl[16] = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b11};

      // reset state
      @(negedge clk);
      check("rst_state", 128'({s_if.cyc[0], s_if.stb[0], s_if.we[0], m_if.ack, m_if.stall}),
                         128'({3'b000, 2'b00, 2'b11}));
      rst = 1'b0;

      // arbitration order, one idle cycle between grants, slave stall
      for (int v = 0; v < 17; v++) begin
         m_if.cyc = tbl[v].cyc; m_if.stb = tbl[v].stb; m_if.we = '0;
         s_if.ack[0] = tbl[v].sack; s_if.stall[0] = tbl[v].sstall;
         #1;
         check($sformatf("tbl%0d", v),
               128'({s_if.cyc[0], s_if.stb[0], m_if.ack, m_if.stall}),
               128'({tbl[v].ecyc, tbl[v].estb, tbl[v].eack, tbl[v].estall}));
         @(negedge clk);
      end

      // single master write then read back
      do_reset();
      drive(0, 1, 0, 0, 0, 0); cycle();
      issue(0, 1, 32'h10, 32'hDEADBEEF);
      wait_acks(0, 1, "t1_wr_ack");
      issue(0, 0, 32'h10, 32'h0);
      wait_acks(0, 2, "t1_rd_ack");
      check("t1_rdata", 128'(rd_last), 128'(32'hDEADBEEF));
      check("t1_m1_acks", 128'(ackcnt[1]), 128'(0));
      drive(0, 0, 0, 0, 0, 0); cycle(); cycle();

      // throttle at MAX_OUTSTANDING with acks held off
      drive(0, 1, 0, 0, 32'h20, 0); cycle();
      ack_hold = 1; a0 = acccnt[0]; b0 = ackcnt[0];
      drive(0, 1, 1, 0, 32'h20, 0);
      repeat (6) cycle();
      check("t3_accepts_held", 128'(acccnt[0] - a0), 128'(MAXO));
      check("t3_stall_full", 128'(m_if.stall[0]), 128'(1));
      ack_hold = 0; n = 0;
      while (acccnt[0] - a0 < 6 && n < 20) begin cycle(); n++; end
      check("t3_accepts_all", 128'(acccnt[0] - a0), 128'(6));
      m_if.stb[0] = 1'b0;
      wait_acks(0, b0 + 6, "t3_acks");
      drive(0, 0, 0, 0, 0, 0); cycle();

      // abandoned cycle: late ack dropped, next grant starts from zero
      drive(0, 1, 0, 0, 32'h30, 0); cycle();
      ack_hold = 1;
      issue(0, 0, 32'h30, 0);
      drive(0, 0, 0, 0, 0, 0); cycle();
      tot = ackcnt[0] + ackcnt[1];
      ack_hold = 0; cycle(); cycle();
      check("t4_no_late_ack", 128'(ackcnt[0] + ackcnt[1]), 128'(tot));
      drive(1, 1, 0, 0, 32'h34, 0); cycle();
      ack_hold = 1; a0 = acccnt[1]; b0 = ackcnt[1];
      drive(1, 1, 1, 0, 32'h34, 0);
      repeat (5) cycle();
      check("t4_fresh_count", 128'(acccnt[1] - a0), 128'(MAXO));
      ack_hold = 0; m_if.stb[1] = 1'b0;
      wait_acks(1, b0 + MAXO, "t4_acks");
      drive(1, 0, 0, 0, 0, 0); cycle();

      // reset mid-burst with two outstanding on master 1
      drive(1, 1, 0, 0, 32'h40, 0); cycle();
      ack_hold = 1;
      issue(1, 0, 32'h40, 0);
      issue(1, 0, 32'h44, 0);
      drive(0, 1, 0, 0, 0, 0);
      rst = 1'b1; s_if.ack[0] = 1'b1;
      #1;
      check("t5_rst_now", 128'({s_if.cyc[0], s_if.stb[0], s_if.we[0], m_if.ack, m_if.stall}),
                          128'({3'b000, 2'b00, 2'b11}));
      do_reset();
      drive(0, 1, 0, 0, 0, 0); drive(1, 1, 0, 0, 0, 0);
      cycle();
      check("t5_m0_first", 128'(m_if.stall), 128'(2'b10));
      check("t5_no_ack", 128'(ackcnt[0] + ackcnt[1]), 128'(0));
      drive(0, 0, 0, 0, 0, 0); drive(1, 0, 0, 0, 0, 0); cycle();

      // random traffic against the reference model
      rnd = 1;
      repeat (600) begin
         for (int i = 0; i < NM; i++) begin
            if (m_if.cyc[i]) begin
               if ($urandom_range(0, 11) == 0) m_if.cyc[i] = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
               m_if.cyc[i] = 1'b1;
            end
            m_if.stb[i]   = m_if.cyc[i] & ($urandom_range(0, 1) == 1);
            m_if.we[i]    = ($urandom_range(0, 1) == 1);
            m_if.adr[i]   = 32'($urandom_range(0, 255)) << 2;
            m_if.dat_w[i] = $urandom;
            m_if.sel[i]   = 4'($urandom_range(0, 15));
         end
         cycle();
      end
      rnd = 0;
      for (int i = 0; i < NM; i++) drive(i, 0, 0, 0, 0, 0);
      repeat (8) cycle();

      $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d vectors applied", vec_n);
      $fatal(1);
   end

endmodule
